// File: rtl/fifo_arb_pkg.sv
// Shared defaults, state type and index-width helper for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_SIZE_BITS = 5;
  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_MAX_BURST = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Bits needed to index n requesters (at least one).
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = DEF_NREQ
) (
  input  logic [N-1:0]           req,
  input  logic [idx_bits(N)-1:0] ptr,
  output logic [idx_bits(N)-1:0] grant,
  output logic                   any
);

  localparam int unsigned IW = idx_bits(N);
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] pos;

  // Scan offsets from the farthest down so the nearest request to ptr wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      if (req[pos[IW-1:0]]) begin
        grant = pos[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding the write side of a synchronous FIFO.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SIZE_BITS = DEF_SIZE_BITS,
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]                req_last,
  output logic [NREQ-1:0]                req_ready,
  input  logic                           fifo_full,
  input  logic [SIZE_BITS:0]             fifo_count,
  output logic                           fifo_write,
  output logic [WIDTH-1:0]               fifo_data_in,
  output logic [idx_bits(NREQ)-1:0]      owner,
  output logic                           busy,
  output logic                           burst_err
);

  localparam int unsigned OW   = idx_bits(NREQ);
  localparam int unsigned CW   = SIZE_BITS + 1;
  localparam int unsigned SIZE = 1 << SIZE_BITS;
  localparam int unsigned BW   = $clog2(MAX_BURST + 1);

  arb_state_e    state;
  logic [OW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic [OW-1:0] pick_idx;
  logic          pick_any;
  logic          own_valid;
  logic          near_full;
  logic          accept;
  logic          cap_hit;
  logic          end_burst;
  logic [OW-1:0] next_ptr;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign own_valid = req_valid[owner];
  // A write landing this cycle at SIZE-1 fills the FIFO before the next beat could.
  assign near_full = fifo_write && (fifo_count == CW'(SIZE - 1));
  assign accept    = (state == BURST) && req_ready[owner];
  assign cap_hit   = (beat_cnt == BW'(MAX_BURST - 1));
  assign end_burst = accept && (req_last[owner] || cap_hit);
  assign next_ptr  = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
  assign busy      = (state == BURST);

  always_comb begin
    req_ready = '0;
    if (state == BURST) begin
      req_ready[owner] = own_valid && !fifo_full && !near_full;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      beat_cnt     <= '0;
      fifo_write   <= 1'b0;
      fifo_data_in <= '0;
      burst_err    <= 1'b0;
    end else begin
      fifo_write <= accept;
      if (accept) begin
        fifo_data_in <= req_data[owner];
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
          if (end_burst) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
            if (!req_last[owner]) begin
              burst_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomized bench for fifo_wr_arb against a cycle-level reference model.
module tb_fifo_wr_arb;

  localparam int W  = 16;
  localparam int NR = 4;
  localparam int SB = 5;
  localparam int MB = 8;
  localparam int CW = SB + 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][W-1:0]   req_data;
  logic [NR-1:0]          req_last;
  logic [NR-1:0]          req_ready;
  logic                   fifo_full;
  logic [SB:0]            fifo_count;
  logic                   fifo_write;
  logic [W-1:0]           fifo_data_in;
  logic [1:0]             owner;
  logic                   busy;
  logic                   burst_err;

  fifo_wr_arb #(.WIDTH(W), .SIZE_BITS(SB), .NREQ(NR), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy),
    .burst_err    (burst_err)
  );

  always #5 clk = ~clk;

  // Requester beat queues: {last, data}; FIFO occupancy model.
  logic [W:0]    rq [NR][$];
  bit            pause [NR];
  bit            drain;
  int            cnt;

  // Reference model of the arbiter.
  bit            m_busy, m_wr, m_err;
  int            m_owner, m_ptr, m_beats;
  logic [W-1:0]  m_data;
  logic [NR-1:0] exp_ready;

  // Observation logs taken from the DUT.
  logic [W-1:0]  wlog [$];
  int            dlog [$];
  int            dcyc [$];
  bit            prev_busy;
  int            cyc;

  int            n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s timeout observed=expired expected=done", tag);
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < NR; r++) if (rq[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < NR; r++) begin
      if (rq[r].size() > 0) begin
        req_valid[r] = !pause[r];
        req_data[r]  = rq[r][0][W-1:0];
        req_last[r]  = rq[r][0][W];
      end else begin
        req_valid[r] = 1'b0;
        req_data[r]  = W'($urandom);
        req_last[r]  = 1'($urandom_range(0, 1));
      end
    end
    fifo_count = CW'(cnt);
    fifo_full  = (cnt == 32);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    m_wr = 0; m_data = '0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    exp_ready = '0;
    if (m_busy && req_valid[m_owner] && !fifo_full && !(m_wr && cnt == 31))
      exp_ready[m_owner] = 1'b1;
    chk({tag, ".ready"},  32'(req_ready),    32'(exp_ready));
    chk({tag, ".write"},  32'(fifo_write),   32'(m_wr));
    chk({tag, ".data"},   32'(fifo_data_in), 32'(m_data));
    chk({tag, ".owner"},  32'(owner),        32'(m_owner));
    chk({tag, ".busy"},   32'(busy),         32'(m_busy));
    chk({tag, ".err"},    32'(burst_err),    32'(m_err));
    if (fifo_write === 1'b1) wlog.push_back(fifo_data_in);
    if (busy === 1'b1 && !prev_busy) begin
      dlog.push_back(int'(owner));
      dcyc.push_back(cyc);
    end
    prev_busy = (busy === 1'b1);
    cyc++;
  endtask

  // Spec rules applied to the inputs about to be sampled at the next rising edge.
  task automatic model_next();
    bit         nwr, found;
    int         r, c0;
    logic [W:0] beat;
    nwr = 0;
    found = 0;
    if (!m_busy) begin
      for (int k = 0; k < NR; k++) begin
        r = (m_ptr + k) % NR;
        if (!found && req_valid[r]) begin
          found = 1;
          m_owner = r;
        end
      end
      if (found) begin
        m_busy = 1;
        m_beats = 0;
      end
    end else if (exp_ready[m_owner]) begin
      beat = rq[m_owner].pop_front();
      nwr = 1;
      m_data = beat[W-1:0];
      m_beats++;
      if (beat[W] || m_beats == MB) begin
        if (!beat[W]) m_err = 1;
        m_busy = 0;
        m_ptr = (m_owner + 1) % NR;
      end
    end
    c0 = cnt;
    cnt = cnt + (m_wr ? 1 : 0);
    if (drain && c0 > 0) cnt--;
    m_wr = nwr;
  endtask

  // Entered and left just after a falling edge.
  task automatic cycle(input string tag);
    drive_inputs();
    #1;
    check_outputs(tag);
    model_next();
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc, input bit flush);
    reset_n = 1'b0;
    if (flush) for (int r = 0; r < NR; r++) rq[r].delete();
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      drive_inputs();
      #1;
      check_outputs("rst");
      @(negedge clk);
    end
    reset_n = 1'b1;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(all_empty() && !m_busy && !m_wr) && n < budget) begin
      cycle(tag);
      n++;
    end
    if (!(all_empty() && !m_busy && !m_wr)) timeout(tag);
  endtask

  task automatic wait_beats(input string tag, input int o, input int k, input int budget);
    int n;
    n = 0;
    while (!(m_busy && m_owner == o && m_beats >= k) && n < budget) begin
      cycle(tag);
      n++;
    end
    if (!(m_busy && m_owner == o && m_beats >= k)) timeout(tag);
  endtask

  task automatic load(input int r, input int len, input logic [W-1:0] base, input bit with_last);
    for (int i = 0; i < len; i++)
      rq[r].push_back({with_last && (i == len - 1), base + W'(i)});
  endtask

  initial begin
    logic [W-1:0] exp_q [$];
    int n;
    n_cmp = 0; n_bad = 0; cyc = 0; prev_busy = 0;
    reset_n = 1'b0; drain = 1; cnt = 0;
    for (int r = 0; r < NR; r++) pause[r] = 0;
    model_reset();

    // Reset with every requester valid, then continuous 2-beat bursts.
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++) begin
        load(r, 2, W'(r * 256 + b * 16), 1);
        exp_q.push_back(W'(r * 256 + b * 16));
        exp_q.push_back(W'(r * 256 + b * 16 + 1));
      end
    @(negedge clk);
    do_reset(3, 0);
    wlog.delete(); dlog.delete(); dcyc.delete();
    run_until_idle("rr", 100);
    chk("rr.grants", 32'(dlog.size()), 32'd8);
    for (int k = 0; k < 5; k++) chk("rr.order", 32'(dlog[k]), 32'(k % NR));
    for (int k = 0; k < 4; k++) chk("rr.burst_cycles", 32'(dcyc[k+1] - dcyc[k]), 32'd3);
    chk("rr.nwrites", 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("rr.wdata", 32'(wlog[i]), 32'(exp_q[i]));

    // FIFO one slot from full: one beat goes in, rest wait for reads.
    wlog.delete();
    cnt = 31; drain = 0;
    load(1, 4, 16'hB000, 1);
    repeat (10) cycle("bp");
    chk("bp.held_writes", 32'(wlog.size()), 32'd1);
    chk("bp.first", 32'(wlog[0]), 32'hB000);
    drain = 1;
    run_until_idle("bp", 100);
    chk("bp.nwrites", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp.wdata", 32'(wlog[i]), 32'(16'hB000 + i));

    // Owner goes quiet mid-burst while others request: grant held.
    dlog.delete();
    load(2, 4, 16'hD000, 1);
    load(0, 2, 16'hE000, 1);
    load(3, 2, 16'hF000, 1);
    wait_beats("idle", 2, 2, 20);
    pause[2] = 1;
    cycle("idle");
    wlog.delete();
    repeat (4) cycle("idle");
    chk("idle.writes", 32'(wlog.size()), 32'd0);
    chk("idle.owner", 32'(owner), 32'd2);
    chk("idle.busy", 32'(busy), 32'd1);
    pause[2] = 0;
    run_until_idle("idle", 100);
    chk("idle.grants", 32'(dlog.size()), 32'd3);
    chk("idle.g0", 32'(dlog[0]), 32'd2);
    chk("idle.g1", 32'(dlog[1]), 32'd3);
    chk("idle.g2", 32'(dlog[2]), 32'd0);

    // Ten beats without last: forced release after eight, grant moves on.
    dlog.delete(); wlog.delete();
    load(2, 10, 16'hC000, 0);
    load(3, 2, 16'hA300, 1);
    n = 0;
    while (dlog.size() < 2 && n < 40) begin
      cycle("force");
      n++;
    end
    if (dlog.size() < 2) timeout("force");
    chk("force.g0", 32'(dlog[0]), 32'd2);
    chk("force.g1", 32'(dlog[1]), 32'd3);
    chk("force.err", 32'(burst_err), 32'd1);
    chk("force.nwrites", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("force.wdata", 32'(wlog[i]), 32'(16'hC000 + i));
    repeat (12) cycle("force");
    do_reset(2, 1);
    chk("force.err_cleared", 32'(burst_err), 32'd0);

    // Reset after three of five beats; arbitration restarts from requester 0.
    load(1, 1, 16'h4100, 1);
    run_until_idle("mid", 20);
    load(3, 5, 16'h4300, 1);
    wait_beats("mid", 3, 3, 20);
    do_reset(1, 1);
    chk("mid.write", 32'(fifo_write), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.owner", 32'(owner), 32'd0);
    dlog.delete();
    load(0, 1, 16'h4000, 1);
    load(2, 1, 16'h4200, 1);
    run_until_idle("mid", 20);
    chk("mid.g0", 32'(dlog[0]), 32'd0);
    chk("mid.g1", 32'(dlog[1]), 32'd2);

    // Random traffic, pauses and FIFO drain rate.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (rq[r].size() == 0 && $urandom_range(0, 3) == 0)
          load(r, int'($urandom_range(1, 10)), W'($urandom), 1);
        pause[r] = ($urandom_range(0, 7) == 0);
      end
      drain = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end
    for (int r = 0; r < NR; r++) pause[r] = 0;
    drain = 1;
    run_until_idle("rand", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
